// File: rtl/write_to_ddr3_if.sv
// Avalon-MM write port between the frame writer and the DDR3 controller.
// Latency: none, wires only.
// Backpressure: ddr3_avl_ready from the controller stalls the current beat.
interface write_to_ddr3_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                    ddr3_avl_ready;
  logic                    ddr3_avl_burstbegin;
  logic [2:0]              ddr3_avl_size;
  logic                    ddr3_avl_write_req;
  logic [25:0]             ddr3_avl_addr;
  logic [DATA_WIDTH-1:0]   ddr3_avl_wdata;
  logic [DATA_WIDTH/8-1:0] ddr3_avl_be;

  modport master (
    input  ddr3_avl_ready,
    output ddr3_avl_burstbegin, ddr3_avl_size, ddr3_avl_write_req,
    output ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_be
  );

  modport slave (
    output ddr3_avl_ready,
    input  ddr3_avl_burstbegin, ddr3_avl_size, ddr3_avl_write_req,
    input  ddr3_avl_addr, ddr3_avl_wdata, ddr3_avl_be
  );
endinterface

// File: rtl/write_to_ddr3.sv
// Drains a show-ahead pixel FIFO in 4-beat Avalon bursts into one half of the DDR3 frame double-buffer.
// Latency: burst starts 1 cycle after the FIFO holds 4 words; 1 idle cycle between bursts, IDLE between frames.
// Backpressure: ddr3_avl_ready low holds the beat and stops popping; a full target buffer parks the writer in IDLE.
module write_to_ddr3 #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 1024,
  parameter int DATA_WIDTH   = 64,
  parameter int FIFO_USED_W  = 9
) (
  input  logic                   ddr3_clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  wr_fifo_data,
  input  logic [FIFO_USED_W-1:0] wr_fifo_used,
  output logic                   wr_fifo_rd,
  input  logic [25:0]            ddr3_buffer0_offset,
  input  logic [25:0]            ddr3_buffer1_offset,
  input  logic                   clear_buffer0,
  input  logic                   clear_buffer1,
  output logic                   buffer0_full,
  output logic                   buffer1_full,
  output logic                   frame_done,
  write_to_ddr3_if.master        avl
);

  localparam int BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) / 4;
  localparam int BCW    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [BCW-1:0] LAST_BURST = BCW'(BURSTS - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_DATA = 2'd1;
  localparam logic [1:0] BURST     = 2'd2;

  logic [1:0]     state;
  logic           write_req;
  logic           burstbegin;
  logic [1:0]     full;
  logic           buffer_sel;
  logic [1:0]     beat;
  logic [BCW-1:0] burst_cnt;
  logic [25:0]    addr;

  logic accept;
  logic frame_end;

  // A beat moves when the controller takes it; the FIFO pops on exactly that term
  assign accept     = write_req & avl.ddr3_avl_ready;
  assign frame_end  = accept && (beat == 2'd3) && (burst_cnt == LAST_BURST);
  assign wr_fifo_rd = accept;

  assign avl.ddr3_avl_write_req  = write_req;
  assign avl.ddr3_avl_burstbegin = burstbegin;
  assign avl.ddr3_avl_addr       = addr;
  assign avl.ddr3_avl_size       = 3'b100;
  assign avl.ddr3_avl_wdata      = wr_fifo_data;
  assign avl.ddr3_avl_be         = '1;

  assign buffer0_full = full[0];
  assign buffer1_full = full[1];

  // Burst sequencer: pick a free buffer, wait for a full burst of data, issue 4 beats
  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      write_req  <= 1'b0;
      burstbegin <= 1'b0;
      frame_done <= 1'b0;
      buffer_sel <= 1'b0;
      beat       <= 2'd0;
      burst_cnt  <= '0;
      addr       <= 26'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!full[buffer_sel]) begin
            addr      <= buffer_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
            burst_cnt <= '0;
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (wr_fifo_used >= FIFO_USED_W'(4)) begin
            write_req  <= 1'b1;
            burstbegin <= 1'b1;
            beat       <= 2'd0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            burstbegin <= 1'b0;
            if (beat == 2'd3) begin
              write_req <= 1'b0;
              burst_cnt <= burst_cnt + 1'b1;
              addr      <= addr + 26'd4;
              if (burst_cnt == LAST_BURST) begin
                frame_done <= 1'b1;
                buffer_sel <= ~buffer_sel;
                state      <= IDLE;
              end else begin
                state <= WAIT_DATA;
              end
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer flags: frame completion sets, reader clears; completion wins a same-cycle collision
  always_ff @(posedge ddr3_clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 2'b00;
    end else begin
      if (frame_end && !buffer_sel)  full[0] <= 1'b1;
      else if (clear_buffer0)        full[0] <= 1'b0;
      if (frame_end && buffer_sel)   full[1] <= 1'b1;
      else if (clear_buffer1)        full[1] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_to_ddr3.sv
// Scoreboard bench for write_to_ddr3 with an 8x2 image (4 bursts per frame).
// Stimulus queues expected beats/frames; a negedge monitor checks every accepted beat.
// The bench models the show-ahead FIFO and drives ddr3_avl_ready directly.
module tb_write_to_ddr3;

  typedef struct {
    logic [25:0] addr;
    logic [63:0] data;
    logic        bb;
  } beat_t;

  logic        ddr3_clk = 1'b0;
  logic        reset_n;
  logic [63:0] wr_fifo_data = 64'd0;
  logic [8:0]  wr_fifo_used = 9'd0;
  logic        wr_fifo_rd;
  logic        clear_buffer0, clear_buffer1;
  logic        buffer0_full, buffer1_full, frame_done;

  write_to_ddr3_if #(.DATA_WIDTH(64)) avl_if ();

  write_to_ddr3 #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .DATA_WIDTH(64), .FIFO_USED_W(9)
  ) dut (
    .ddr3_clk(ddr3_clk), .reset_n(reset_n),
    .wr_fifo_data(wr_fifo_data), .wr_fifo_used(wr_fifo_used), .wr_fifo_rd(wr_fifo_rd),
    .ddr3_buffer0_offset(26'h100), .ddr3_buffer1_offset(26'h200),
    .clear_buffer0(clear_buffer0), .clear_buffer1(clear_buffer1),
    .buffer0_full(buffer0_full), .buffer1_full(buffer1_full), .frame_done(frame_done),
    .avl(avl_if)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  logic [63:0] fifo_q[$];
  logic [63:0] pend_q[$];
  beat_t       exp_q[$];
  int          exp_frame_q[$];
  logic [25:0] cur_base;
  int          cur_word;
  int          frame_no = 0;
  logic        prev_fd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Show-ahead FIFO model: pops on wr_fifo_rd, absorbs new words, emptied by the source during reset
  always @(posedge ddr3_clk) begin
    if (wr_fifo_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    if (!reset_n) fifo_q.delete();
    wr_fifo_used <= 9'(fifo_q.size());
    wr_fifo_data <= (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
  end

  // Monitor: compare each accepted beat and each frame_done pulse with the scoreboard
  always @(negedge ddr3_clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_frame_q.delete();
      prev_fd = 1'b0;
    end else begin
      if (avl_if.ddr3_avl_write_req) begin
        chk("fifo_rd", {63'd0, wr_fifo_rd}, {63'd0, avl_if.ddr3_avl_ready});
        if (avl_if.ddr3_avl_ready) begin
          if (exp_q.size() == 0) begin
            chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_addr", {38'd0, avl_if.ddr3_avl_addr}, {38'd0, e.addr});
            chk("beat_wdata", avl_if.ddr3_avl_wdata, e.data);
            chk("beat_burstbegin", {63'd0, avl_if.ddr3_avl_burstbegin}, {63'd0, e.bb});
            chk("beat_size", {61'd0, avl_if.ddr3_avl_size}, 64'd4);
            chk("beat_be", {56'd0, avl_if.ddr3_avl_be}, 64'hFF);
          end
        end
      end
      if (frame_done) begin
        chk("frame_done_single", {63'd0, prev_fd}, 64'd0);
        if (exp_frame_q.size() == 0) begin
          chk("frame_unexpected", 64'(exp_frame_q.size()), 64'd1);
        end else begin
          int b;
          b = exp_frame_q.pop_front();
          chk("frame_buffer_full", {63'd0, (b == 0) ? buffer0_full : buffer1_full}, 64'd1);
        end
      end
      prev_fd = frame_done;
    end
  end

  task automatic start_frame(input logic [25:0] base, input int bufidx);
    cur_base = base;
    cur_word = 0;
    frame_no++;
    exp_frame_q.push_back(bufidx);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.data = {32'hC0DE0000 + 32'(frame_no), 32'(cur_word)};
      e.addr = cur_base + 26'(4 * (cur_word / 4));
      e.bb   = (cur_word % 4) == 0;
      pend_q.push_back(e.data);
      exp_q.push_back(e);
      cur_word++;
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_done && n < 300) begin
      @(negedge ddr3_clk);
      n++;
    end
    chk("frame_timeout", 64'(n < 300), 64'd1);
    @(posedge ddr3_clk);
    #1;
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_cnt != target && n < 300) begin
      @(posedge ddr3_clk);
      #1;
      n++;
    end
    chk("pop_wait", 64'(pop_cnt), 64'(target));
  endtask

  task automatic pulse_clear(input int bufidx);
    @(posedge ddr3_clk); #1;
    if (bufidx == 0) clear_buffer0 = 1'b1; else clear_buffer1 = 1'b1;
    @(posedge ddr3_clk); #1;
    clear_buffer0 = 1'b0;
    clear_buffer1 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write_req"}, {63'd0, avl_if.ddr3_avl_write_req}, 64'd0);
    chk({tag, "_burstbegin"}, {63'd0, avl_if.ddr3_avl_burstbegin}, 64'd0);
    chk({tag, "_addr"}, {38'd0, avl_if.ddr3_avl_addr}, 64'd0);
    chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    chk({tag, "_buffer0_full"}, {63'd0, buffer0_full}, 64'd0);
    chk({tag, "_buffer1_full"}, {63'd0, buffer1_full}, 64'd0);
    chk({tag, "_fifo_rd"}, {63'd0, wr_fifo_rd}, 64'd0);
  endtask

  initial begin
    int pb;
    int seen;
    reset_n = 1'b0;
    avl_if.ddr3_avl_ready = 1'b1;
    clear_buffer0 = 1'b0;
    clear_buffer1 = 1'b0;
    repeat (3) @(posedge ddr3_clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge ddr3_clk); #1;
    reset_n = 1'b1;

    // Frame 1: 16 words into buffer0 at 0x100..0x10C
    start_frame(26'h100, 0);
    push_words(16);
    wait_frame();
    chk("f1_buffer0_full", {63'd0, buffer0_full}, 64'd1);
    chk("f1_buffer1_full", {63'd0, buffer1_full}, 64'd0);

    // Frame 2 into buffer1: stall 3 cycles on beat 2, clear_buffer1 collides with completion
    pb = pop_cnt;
    start_frame(26'h200, 1);
    push_words(16);
    wait_pops(pb + 2);
    avl_if.ddr3_avl_ready = 1'b0;
    repeat (3) begin
      @(negedge ddr3_clk);
      chk("stall_write_req", {63'd0, avl_if.ddr3_avl_write_req}, 64'd1);
      chk("stall_addr", {38'd0, avl_if.ddr3_avl_addr}, 64'h200);
      chk("stall_wdata", avl_if.ddr3_avl_wdata, {32'hC0DE0002, 32'd2});
      chk("stall_fifo_rd", {63'd0, wr_fifo_rd}, 64'd0);
      chk("stall_used", {55'd0, wr_fifo_used}, 64'd14);
      @(posedge ddr3_clk); #1;
    end
    avl_if.ddr3_avl_ready = 1'b1;
    wait_pops(pb + 15);
    clear_buffer1 = 1'b1;
    @(posedge ddr3_clk); #1;
    clear_buffer1 = 1'b0;
    wait_frame();
    chk("f2_pops", 64'(pop_cnt - pb), 64'd16);
    chk("f2_set_wins_clear", {63'd0, buffer1_full}, 64'd1);
    chk("f2_buffer0_full", {63'd0, buffer0_full}, 64'd1);

    // Frame 3: both buffers full, writer waits in IDLE until buffer0 clears
    start_frame(26'h100, 0);
    push_words(16);
    seen = 0;
    repeat (20) begin
      @(negedge ddr3_clk);
      if (avl_if.ddr3_avl_write_req) seen++;
    end
    chk("both_full_no_write", 64'(seen), 64'd0);
    chk("both_full_used", {55'd0, wr_fifo_used}, 64'd16);
    pulse_clear(0);
    wait_frame();
    chk("f3_buffer0_full", {63'd0, buffer0_full}, 64'd1);
    chk("f3_buffer1_full", {63'd0, buffer1_full}, 64'd1);

    // Frame 4 into buffer1: FIFO holds only 3 words, burst starts once the 4th lands
    pulse_clear(1);
    start_frame(26'h200, 1);
    push_words(3);
    repeat (6) @(negedge ddr3_clk);
    chk("used3_no_req", {63'd0, avl_if.ddr3_avl_write_req}, 64'd0);
    chk("used3_used", {55'd0, wr_fifo_used}, 64'd3);
    @(posedge ddr3_clk); #1;
    push_words(1);
    @(negedge ddr3_clk);
    chk("used4_req_a", {63'd0, avl_if.ddr3_avl_write_req}, 64'd0);
    @(negedge ddr3_clk);
    chk("used4_req_b", {63'd0, avl_if.ddr3_avl_write_req}, 64'd0);
    @(negedge ddr3_clk);
    chk("used4_req_c", {63'd0, avl_if.ddr3_avl_write_req}, 64'd1);
    chk("used4_burstbegin", {63'd0, avl_if.ddr3_avl_burstbegin}, 64'd1);
    push_words(12);
    wait_frame();
    chk("f4_buffer1_full", {63'd0, buffer1_full}, 64'd1);

    // Frame 5: reset in the middle of the third burst, then restart at 0x100
    pulse_clear(0);
    pb = pop_cnt;
    start_frame(26'h100, 0);
    push_words(16);
    wait_pops(pb + 9);
    chk("pre_reset_write_req", {63'd0, avl_if.ddr3_avl_write_req}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge ddr3_clk);
    #1;
    reset_n = 1'b1;
    start_frame(26'h100, 0);
    push_words(16);
    wait_frame();
    chk("f6_buffer0_full", {63'd0, buffer0_full}, 64'd1);
    chk("f6_buffer1_full", {63'd0, buffer1_full}, 64'd0);

    repeat (10) @(negedge ddr3_clk);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("frames_left", 64'(exp_frame_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
